trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter EXC_PORTS, default 3, number of exception-reporting pipelines.
REQ-002 SHALL have port clk  input  1  core clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port i_exc_vld  input  EXC_PORTS  per-port exception report valid.
REQ-005 SHALL have port i_exc_robIdx  input  EXC_PORTS x robIdx_t  ROB index of faulting instruction.
REQ-006 SHALL have port i_exc_flag  input  EXC_PORTS  ROB wrap flag of faulting instruction.
REQ-007 SHALL have port i_exc_cause  input  EXC_PORTS x 6  rv_trap_t::exception code.
REQ-008 SHALL have port i_exc_tval  input  EXC_PORTS x XLEN  trap value.
REQ-009 SHALL have port i_squash_vld / i_squash_robIdx / i_squash_flag  input  1 / robIdx_t / 1  flush of all instructions younger than the given one.
REQ-010 SHALL have port i_commit_robIdx / i_commit_flag  input  robIdx_t / 1  current ROB head.
REQ-011 SHALL have port i_commit_vld  input  1  ROB head is complete and requests retirement.
REQ-012 SHALL have port i_irq_pend  input  XLEN  mip & mie, already masked.
REQ-013 SHALL have port i_irq_en  input  1  global interrupt enable for current privilege.
REQ-014 SHALL have port o_commit_block  output  1  forbids ROB retirement this cycle.
REQ-015 SHALL have port o_trap_vld / o_trap_cause / o_trap_tval / o_trap_robIdx  output  1 / XLEN / XLEN / robIdx_t  trap request to CSR unit; cause bit XLEN-1 = interrupt.
REQ-016 SHALL have port i_trap_ack  input  1  CSR unit accepted trap.

Function
REQ-017 Age: A older than B iff (flagA==flagB && idxA<idxB) || (flagA!=flagB && idxA>idxB); equal idx and flag = same instruction.
REQ-018 FSM states: IDLE (nothing held), HELD (one exception recorded), TRAP (o_trap_vld high), DRAIN (one-cycle flush bubble).
REQ-019 Same-cycle reports: oldest wins; same instruction on several ports -> lowest port index wins.
REQ-020 IDLE + any report -> HELD next cycle, winner stored (robIdx, flag, cause, tval).
REQ-021 HELD + report strictly older than held -> held replaced; same or younger -> ignored.
REQ-022 i_squash_vld applied before reports in the same cycle: held entry strictly younger than squash point -> cleared (HELD->IDLE unless a surviving report arrives); reports strictly younger than squash point dropped.
REQ-023 HELD + i_commit_vld + commit head equals held entry -> TRAP next cycle, cause = zero-extended exception code, tval = held tval.
REQ-024 IDLE or HELD, i_irq_en=1, i_irq_pend!=0, i_commit_vld=1 -> TRAP next cycle with interrupt; interrupt wins over a held exception at head the same cycle; held exception discarded.
REQ-025 Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5; other bits ignored; cause = {1'b1, code}; tval = 0; robIdx = commit head.
REQ-026 o_commit_block = 1 whenever a trap is being taken this cycle (REQ-023/024 condition), and in TRAP and DRAIN; 0 otherwise.
REQ-027 TRAP holds o_trap_* stable until i_trap_ack; ack -> DRAIN; DRAIN -> IDLE unconditionally after one cycle.
REQ-028 Reports and squashes in TRAP and DRAIN are ignored (pipeline is being flushed).
REQ-029 Latency: report -> HELD 1 cycle; matching commit -> o_trap_vld 1 cycle; ack -> IDLE 2 cycles.
REQ-030 o_trap_cause/tval/robIdx are 0 whenever o_trap_vld=0.

Reset
REQ-031 rst low asynchronously forces IDLE, clears held entry, o_trap_vld=0, o_commit_block=0, all o_trap_* fields 0; release takes effect on next clk edge.
REQ-032 Reset mid-TRAP discards the pending trap; no ack required.

Verification
REQ-033 Port0 loadFault idx5 flag0, port2 instIllegal idx3 flag0 same cycle -> held idx3 cause 2; commit head idx3 -> o_trap_vld, cause 2, o_commit_block=1.
REQ-034 Held idx30 flag0, new report idx1 flag1 -> ignored (younger after wrap); report idx28 flag0 -> replaces.
REQ-035 Held idx10, squash at idx8 -> IDLE; same cycle report idx7 -> HELD idx7.
REQ-036 i_irq_pend bits 7 and 11, i_irq_en=1, commit valid -> cause = 2^(XLEN-1)+11, tval 0; ack -> DRAIN -> IDLE.
REQ-037 Held exception at commit head plus pending mTimer -> interrupt cause 2^(XLEN-1)+7 taken, exception dropped.
REQ-038 rst low while in TRAP -> all outputs 0 immediately, no clock required.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap controller: records the oldest reported exception, arbitrates it against
// pending interrupts at the ROB head, and hands the trap to the CSR unit.
module trap_ctrl #(
    parameter int EXC_PORTS = 3,
    parameter int XLEN      = 64,
    parameter int ROB_W     = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [EXC_PORTS-1:0]                i_exc_vld,
    input  logic [EXC_PORTS-1:0][ROB_W-1:0]     i_exc_robIdx,
    input  logic [EXC_PORTS-1:0]                i_exc_flag,
    input  logic [EXC_PORTS-1:0][5:0]           i_exc_cause,
    input  logic [EXC_PORTS-1:0][XLEN-1:0]      i_exc_tval,
    input  logic                                i_squash_vld,
    input  logic [ROB_W-1:0]                    i_squash_robIdx,
    input  logic                                i_squash_flag,
    input  logic [ROB_W-1:0]                    i_commit_robIdx,
    input  logic                                i_commit_flag,
    input  logic                                i_commit_vld,
    input  logic [XLEN-1:0]                     i_irq_pend,
    input  logic                                i_irq_en,
    output logic                                o_commit_block,
    output logic                                o_trap_vld,
    output logic [XLEN-1:0]                     o_trap_cause,
    output logic [XLEN-1:0]                     o_trap_tval,
    output logic [ROB_W-1:0]                    o_trap_robIdx,
    input  logic                                i_trap_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        TRAP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Interrupt lines that can raise a trap: 1, 3, 5, 7, 9, 11.
    localparam logic [XLEN-1:0] IRQ_MASK = {{(XLEN-12){1'b0}}, 12'hAAA};

    function automatic logic is_older(input logic [ROB_W-1:0] a_idx, input logic a_flag,
                                      input logic [ROB_W-1:0] b_idx, input logic b_flag);
        return ((a_flag == b_flag) && (a_idx < b_idx)) ||
               ((a_flag != b_flag) && (a_idx > b_idx));
    endfunction

    state_e            state_q, state_d;
    logic [ROB_W-1:0]  held_idx_q, held_idx_d;
    logic              held_flag_q, held_flag_d;
    logic [5:0]        held_cause_q, held_cause_d;
    logic [XLEN-1:0]   held_tval_q, held_tval_d;
    logic [XLEN-1:0]   trap_cause_q, trap_cause_d;
    logic [XLEN-1:0]   trap_tval_q, trap_tval_d;
    logic [ROB_W-1:0]  trap_idx_q, trap_idx_d;

    logic              active_s, squash_s, held_live_s, replace_s;
    logic              exc_take_s, irq_take_s, take_s, irq_any_s;
    logic [3:0]        irq_code_s;
    logic              win_vld_s, pick_s;
    logic [ROB_W-1:0]  win_idx_s;
    logic              win_flag_s;
    logic [5:0]        win_cause_s;
    logic [XLEN-1:0]   win_tval_s;

    // Arbitration: squash filtering, oldest-report selection, trap conditions.
    always_comb begin
        active_s    = (state_q == IDLE) || (state_q == HELD);
        squash_s    = active_s && i_squash_vld;
        held_live_s = (state_q == HELD) &&
                      !(squash_s && is_older(i_squash_robIdx, i_squash_flag, held_idx_q, held_flag_q));

        win_vld_s   = 1'b0;
        win_idx_s   = '0;
        win_flag_s  = 1'b0;
        win_cause_s = 6'd0;
        win_tval_s  = '0;
        pick_s      = 1'b0;
        // Strict "older" comparison keeps the lowest port on a same-instruction tie.
        for (int p = 0; p < EXC_PORTS; p++) begin
            pick_s = active_s && i_exc_vld[p] &&
                     !(squash_s && is_older(i_squash_robIdx, i_squash_flag,
                                            i_exc_robIdx[p], i_exc_flag[p])) &&
                     (!win_vld_s || is_older(i_exc_robIdx[p], i_exc_flag[p], win_idx_s, win_flag_s));
            win_vld_s   = win_vld_s | pick_s;
            win_idx_s   = pick_s ? i_exc_robIdx[p] : win_idx_s;
            win_flag_s  = pick_s ? i_exc_flag[p]   : win_flag_s;
            win_cause_s = pick_s ? i_exc_cause[p]  : win_cause_s;
            win_tval_s  = pick_s ? i_exc_tval[p]   : win_tval_s;
        end

        replace_s = win_vld_s &&
                    (!held_live_s || is_older(win_idx_s, win_flag_s, held_idx_q, held_flag_q));

        irq_any_s = |(i_irq_pend & IRQ_MASK);
        if (i_irq_pend[11])     irq_code_s = 4'd11;
        else if (i_irq_pend[3]) irq_code_s = 4'd3;
        else if (i_irq_pend[7]) irq_code_s = 4'd7;
        else if (i_irq_pend[9]) irq_code_s = 4'd9;
        else if (i_irq_pend[1]) irq_code_s = 4'd1;
        else if (i_irq_pend[5]) irq_code_s = 4'd5;
        else                    irq_code_s = 4'd0;

        irq_take_s = active_s && i_irq_en && irq_any_s && i_commit_vld;
        exc_take_s = held_live_s && i_commit_vld &&
                     (i_commit_robIdx == held_idx_q) && (i_commit_flag == held_flag_q);
        take_s     = irq_take_s || exc_take_s;
    end

    // Next-state and held/trap register update.
    always_comb begin
        state_d      = state_q;
        held_idx_d   = held_idx_q;
        held_flag_d  = held_flag_q;
        held_cause_d = held_cause_q;
        held_tval_d  = held_tval_q;
        trap_cause_d = trap_cause_q;
        trap_tval_d  = trap_tval_q;
        trap_idx_d   = trap_idx_q;
        case (state_q)
            IDLE, HELD: begin
                if (take_s) begin
                    state_d      = TRAP;
                    held_idx_d   = '0;
                    held_flag_d  = 1'b0;
                    held_cause_d = 6'd0;
                    held_tval_d  = '0;
                    trap_idx_d   = i_commit_robIdx;
                    if (irq_take_s) begin
                        trap_cause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
                        trap_tval_d  = '0;
                    end else begin
                        trap_cause_d = {{(XLEN-6){1'b0}}, held_cause_q};
                        trap_tval_d  = held_tval_q;
                    end
                end else if (replace_s) begin
                    state_d      = HELD;
                    held_idx_d   = win_idx_s;
                    held_flag_d  = win_flag_s;
                    held_cause_d = win_cause_s;
                    held_tval_d  = win_tval_s;
                end else if (held_live_s) begin
                    state_d = HELD;
                end else begin
                    state_d      = IDLE;
                    held_idx_d   = '0;
                    held_flag_d  = 1'b0;
                    held_cause_d = 6'd0;
                    held_tval_d  = '0;
                end
            end
            TRAP: begin
                if (i_trap_ack) begin
                    state_d      = DRAIN;
                    trap_cause_d = '0;
                    trap_tval_d  = '0;
                    trap_idx_d   = '0;
                end else begin
                    state_d = TRAP;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                trap_cause_d = '0;
                trap_tval_d  = '0;
                trap_idx_d   = '0;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            held_idx_q   <= '0;
            held_flag_q  <= 1'b0;
            held_cause_q <= 6'd0;
            held_tval_q  <= '0;
            trap_cause_q <= '0;
            trap_tval_q  <= '0;
            trap_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            held_idx_q   <= held_idx_d;
            held_flag_q  <= held_flag_d;
            held_cause_q <= held_cause_d;
            held_tval_q  <= held_tval_d;
            trap_cause_q <= trap_cause_d;
            trap_tval_q  <= trap_tval_d;
            trap_idx_q   <= trap_idx_d;
        end
    end

    // Retirement must stall in the cycle a trap is taken, not only after it.
    always_comb begin
        o_commit_block = rst && (take_s || (state_q == TRAP) || (state_q == DRAIN));
        o_trap_vld     = (state_q == TRAP);
        o_trap_cause   = trap_cause_q;
        o_trap_tval    = trap_tval_q;
        o_trap_robIdx  = trap_idx_q;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reports, age/wrap arbitration, squash, interrupts, reset.
module tb_trap_ctrl;
    localparam int NP    = 3;
    localparam int XLEN  = 64;
    localparam int ROB_W = 5;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NP-1:0]                 exc_vld;
    logic [NP-1:0][ROB_W-1:0]      exc_idx;
    logic [NP-1:0]                 exc_flag;
    logic [NP-1:0][5:0]            exc_cause;
    logic [NP-1:0][XLEN-1:0]       exc_tval;
    logic                          sq_vld, sq_flag, cm_flag, cm_vld, irq_en, ack;
    logic [ROB_W-1:0]              sq_idx, cm_idx;
    logic [XLEN-1:0]               irq_pend;
    logic                          block, tvld;
    logic [XLEN-1:0]               tcause, ttval;
    logic [ROB_W-1:0]              tidx;
    int                            passed = 0;
    int                            total  = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.EXC_PORTS(NP), .XLEN(XLEN), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst),
        .i_exc_vld(exc_vld), .i_exc_robIdx(exc_idx), .i_exc_flag(exc_flag),
        .i_exc_cause(exc_cause), .i_exc_tval(exc_tval),
        .i_squash_vld(sq_vld), .i_squash_robIdx(sq_idx), .i_squash_flag(sq_flag),
        .i_commit_robIdx(cm_idx), .i_commit_flag(cm_flag), .i_commit_vld(cm_vld),
        .i_irq_pend(irq_pend), .i_irq_en(irq_en),
        .o_commit_block(block), .o_trap_vld(tvld), .o_trap_cause(tcause),
        .o_trap_tval(ttval), .o_trap_robIdx(tidx), .i_trap_ack(ack)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        exc_vld = '0; exc_idx = '0; exc_flag = '0; exc_cause = '0; exc_tval = '0;
        sq_vld = 1'b0; sq_idx = '0; sq_flag = 1'b0;
        cm_idx = '0; cm_flag = 1'b0; cm_vld = 1'b0;
        irq_pend = '0; irq_en = 1'b0; ack = 1'b0;
    endtask

    task automatic rep(input int p, input logic [ROB_W-1:0] idx, input logic flag,
                       input logic [5:0] cause, input logic [XLEN-1:0] tval);
        exc_vld[p] = 1'b1; exc_idx[p] = idx; exc_flag[p] = flag;
        exc_cause[p] = cause; exc_tval[p] = tval;
    endtask

    task automatic commit(input logic [ROB_W-1:0] idx, input logic flag);
        cm_idx = idx; cm_flag = flag; cm_vld = 1'b1;
    endtask

    task automatic ack_drain(input string tag);
        ack = 1'b1;
        step();
        clr();
        check({tag, "_drain_vld"}, {63'd0, tvld}, 64'd0);
        check({tag, "_drain_block"}, {63'd0, block}, 64'd1);
        step();
        check({tag, "_idle_block"}, {63'd0, block}, 64'd0);
    endtask

    initial begin
        // Reset held with an interrupt pending at the head: nothing may leak out.
        clr();
        rst = 1'b0;
        irq_en = 1'b1; irq_pend = 64'h800; commit(5'd0, 1'b0);
        #12;
        check("rst_block", {63'd0, block}, 64'd0);
        check("rst_vld", {63'd0, tvld}, 64'd0);
        check("rst_cause", tcause, 64'd0);
        clr();
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        check("idle_vld", {63'd0, tvld}, 64'd0);
        check("idle_block", {63'd0, block}, 64'd0);

        // Two same-cycle reports: idx3 is older and wins.
        rep(0, 5'd5, 1'b0, 6'd5, 64'h1000);
        rep(2, 5'd3, 1'b0, 6'd2, 64'h2222);
        settle();
        check("t1_report_block", {63'd0, block}, 64'd0);
        step(); clr();
        commit(5'd5, 1'b0); settle();
        check("t1_nonhead_block", {63'd0, block}, 64'd0);
        commit(5'd3, 1'b0); settle();
        check("t1_head_block", {63'd0, block}, 64'd1);
        step(); clr();
        check("t1_vld", {63'd0, tvld}, 64'd1);
        check("t1_cause", tcause, 64'd2);
        check("t1_tval", ttval, 64'h2222);
        check("t1_idx", {59'd0, tidx}, 64'd3);
        check("t1_block", {63'd0, block}, 64'd1);
        step();
        check("t1_hold_vld", {63'd0, tvld}, 64'd1);
        check("t1_hold_cause", tcause, 64'd2);
        ack_drain("t1");

        // Wrap-around age: idx1/flag1 is younger than idx30/flag0, idx28/flag0 older.
        rep(0, 5'd30, 1'b0, 6'd4, 64'h30);
        step(); clr();
        rep(1, 5'd1, 1'b1, 6'd6, 64'h1);
        step(); clr();
        commit(5'd1, 1'b1); settle();
        check("t2_wrap_ignored", {63'd0, block}, 64'd0);
        clr();
        rep(0, 5'd28, 1'b0, 6'd7, 64'h28);
        step(); clr();
        commit(5'd30, 1'b0); settle();
        check("t2_replaced_gone", {63'd0, block}, 64'd0);
        commit(5'd28, 1'b0); settle();
        check("t2_head_block", {63'd0, block}, 64'd1);
        step(); clr();
        check("t2_cause", tcause, 64'd7);
        check("t2_tval", ttval, 64'h28);
        check("t2_idx", {59'd0, tidx}, 64'd28);
        ack_drain("t2");

        // Squash: younger point keeps held entry, older point kills it.
        rep(0, 5'd10, 1'b0, 6'd1, 64'hA);
        step(); clr();
        sq_vld = 1'b1; sq_idx = 5'd12;
        step(); clr();
        commit(5'd10, 1'b0); settle();
        check("t3_survive_block", {63'd0, block}, 64'd1);
        clr();
        sq_vld = 1'b1; sq_idx = 5'd8;
        rep(1, 5'd7, 1'b0, 6'd3, 64'h7);
        step(); clr();
        commit(5'd10, 1'b0); settle();
        check("t3_killed_block", {63'd0, block}, 64'd0);
        commit(5'd7, 1'b0); settle();
        check("t3_head_block", {63'd0, block}, 64'd1);
        step(); clr();
        check("t3_cause", tcause, 64'd3);
        check("t3_idx", {59'd0, tidx}, 64'd7);
        ack_drain("t3");
        sq_vld = 1'b1; sq_idx = 5'd8;
        rep(0, 5'd9, 1'b0, 6'd9, 64'h9);
        step(); clr();
        commit(5'd9, 1'b0); settle();
        check("t3_dropped_block", {63'd0, block}, 64'd0);
        clr();

        // Interrupt: bits 7 and 11 pending, 11 has priority.
        irq_en = 1'b1; irq_pend = 64'h880; commit(5'd4, 1'b0); settle();
        check("t4_block", {63'd0, block}, 64'd1);
        step(); clr();
        check("t4_vld", {63'd0, tvld}, 64'd1);
        check("t4_cause", tcause, 64'h8000_0000_0000_000B);
        check("t4_tval", ttval, 64'd0);
        check("t4_idx", {59'd0, tidx}, 64'd4);
        ack_drain("t4");
        irq_en = 1'b0; irq_pend = 64'h800; commit(5'd4, 1'b0); settle();
        check("t4_disabled_block", {63'd0, block}, 64'd0);
        clr();

        // Interrupt beats a held exception at the head; the exception is dropped.
        rep(0, 5'd6, 1'b0, 6'd2, 64'h66);
        step(); clr();
        commit(5'd6, 1'b0); irq_en = 1'b1; irq_pend = 64'h80; settle();
        check("t5_block", {63'd0, block}, 64'd1);
        step(); clr();
        check("t5_cause", tcause, 64'h8000_0000_0000_0007);
        check("t5_tval", ttval, 64'd0);
        check("t5_idx", {59'd0, tidx}, 64'd6);
        ack_drain("t5");
        commit(5'd6, 1'b0); settle();
        check("t5_discarded", {63'd0, block}, 64'd0);
        clr();

        // Priority 9 over 1 and 5; reports and squashes ignored while trapping.
        irq_en = 1'b1; irq_pend = 64'h222; commit(5'd0, 1'b0);
        step(); clr();
        check("t6_cause", tcause, 64'h8000_0000_0000_0009);
        rep(0, 5'd2, 1'b0, 6'd2, 64'h2);
        sq_vld = 1'b1; sq_idx = 5'd1;
        step(); clr();
        check("t6_stable_vld", {63'd0, tvld}, 64'd1);
        check("t6_stable_cause", tcause, 64'h8000_0000_0000_0009);
        ack_drain("t6");
        commit(5'd2, 1'b0); settle();
        check("t6_ignored_block", {63'd0, block}, 64'd0);
        clr();

        // Same instruction on two ports: lowest port wins.
        rep(0, 5'd12, 1'b0, 6'd4, 64'hC0);
        rep(1, 5'd12, 1'b0, 6'd13, 64'hC1);
        step(); clr();
        commit(5'd12, 1'b0);
        step(); clr();
        check("t7_cause", tcause, 64'd4);
        check("t7_tval", ttval, 64'hC0);
        ack_drain("t7");

        // Asynchronous reset in TRAP clears outputs without a clock edge.
        irq_en = 1'b1; irq_pend = 64'h8; commit(5'd1, 1'b0);
        step(); clr();
        check("t8_pre_vld", {63'd0, tvld}, 64'd1);
        rst = 1'b0;
        #2;
        check("t8_rst_vld", {63'd0, tvld}, 64'd0);
        check("t8_rst_cause", tcause, 64'd0);
        check("t8_rst_idx", {59'd0, tidx}, 64'd0);
        check("t8_rst_block", {63'd0, block}, 64'd0);
        rst = 1'b1;
        step();
        check("t8_post_vld", {63'd0, tvld}, 64'd0);
        check("t8_post_block", {63'd0, block}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
